parking_meter_counter: RTL and testbench
========================================

Name: parking_meter_counter

Overview:
- Tracks parking-lot occupancy using two adjacent optical sensors at a single-lane gate.
  - psensor: primary, outer.
  - ssensor: secondary, inner.
- Decodes the sensor pattern sequence to detect complete car entries and exits.
- Maintains a 4-bit occupancy count and a sticky error flag.
- Exposes the FSM state for debug; sits between the raw gate sensors and the display/supervisor logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages on each sensor input synchronizer (minimum 2).
- MAX_COUNT, 15, highest legal occupancy value; must fit in 4 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- psensor  input  1  outer sensor, 1 = beam blocked; asynchronous to clk.
- ssensor  input  1  inner sensor, 1 = beam blocked; asynchronous to clk.
- conteo  output  4  current occupancy count, registered.
- hubo_error  output  1  sticky error flag, registered.
- state  output  3  current FSM state encoding, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizers cleared to 0.
  - state=IDLE (0), conteo=0, hubo_error=0.
  - Reset may assert at any time; all activity aborts and no partial count is applied.
- Inputs:
  - Each sensor passes through SYNC_STAGES flops.
  - FSM acts on the synchronized pair {p,s}, so latency from a pin change to a state change is SYNC_STAGES+1 rising edges.
- State encoding:
  - IDLE=0, IN1=1, IN2=2, IN3=3, OUT1=4, OUT2=5, OUT3=6, ERR=7.
- Transitions (evaluated each clock on synchronized {p,s}; an unlisted pattern means the state holds):
  - IDLE: 10->IN1; 01->OUT1; 11->ERR.
  - IN1: 11->IN2; 00->IDLE (car backed out, no count); 01->ERR.
  - IN2: 01->IN3; 10->IN1; 00->ERR.
  - IN3: 11->IN2; 10->ERR; 00->IDLE with conteo+1.
    - If conteo==MAX_COUNT, go to ERR instead and conteo is unchanged.
  - OUT1: 11->OUT2; 00->IDLE (no count); 10->ERR.
  - OUT2: 10->OUT3; 01->OUT1; 00->ERR.
  - OUT3: 11->OUT2; 01->ERR; 00->IDLE with conteo-1.
    - If conteo==0, go to ERR instead and conteo is unchanged.
  - ERR: hold until 00 is seen, then IDLE. No count change while in ERR.
- Count and error rules:
  - conteo changes by at most 1 per cycle and never wraps.
  - hubo_error is set on the same edge that state becomes ERR.
  - hubo_error stays 1 until reset, including after ERR returns to IDLE.
- Outputs:
  - All outputs are driven directly from flops; no combinational path from inputs.

Test Plan:
- Reset then idle: hold reset=0 for 5 cycles, release with sensors 00 -> conteo=0, hubo_error=0, state=0 throughout.
- Back-out: apply 10,11,10,00, each held 1 cycle beyond sync latency -> state visits 1,2,1,0; conteo stays 0; hubo_error=0. Repeat the sequence -> identical result. Then apply 01 -> state=4 (OUT1).
- Full entry x3 then exit x1: apply 10,11,01,00 three times -> conteo 1,2,3, each step landing one cycle after the synced 00. Then apply 01,11,10,00 -> conteo=2, hubo_error=0.
- Illegal jump: from IDLE apply 11 -> state=7, hubo_error=1. Apply 00 -> state=0; hubo_error remains 1; a following valid entry still increments conteo.
- Boundaries:
  - Exit sequence at conteo=0 -> ERR, conteo stays 0, hubo_error=1.
  - 15 entries -> conteo=15; a 16th entry -> ERR, conteo stays 15.
- Async reset mid-sequence: assert reset in IN2 with conteo=5, between clock edges -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/parking_meter_counter.sv
// Gate occupancy counter: synchronizes two optical sensors and decodes their
// pattern sequence into car entries and exits, keeping a 4-bit count and a sticky error.
module parking_meter_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psensor,
  input  logic       ssensor,
  output logic [3:0] conteo,
  output logic       hubo_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    IN3  = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5,
    OUT3 = 3'd6,
    ERR  = 3'd7
  } state_t;

  localparam logic [3:0] MaxCnt = 4'(MAX_COUNT);

  logic [SYNC_STAGES-1:0] p_sync_q, s_sync_q;
  logic [1:0]             pat;
  state_t                 state_q, state_d;
  logic [3:0]             conteo_q, conteo_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_sync_q <= '0;
      s_sync_q <= '0;
    end else begin
      p_sync_q <= {p_sync_q[SYNC_STAGES-2:0], psensor};
      s_sync_q <= {s_sync_q[SYNC_STAGES-2:0], ssensor};
    end
  end

  assign pat = {p_sync_q[SYNC_STAGES-1], s_sync_q[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      conteo_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      conteo_q <= conteo_d;
      err_q    <= err_d;
    end
  end

  // Patterns not listed for a state leave it unchanged.
  always_comb begin
    state_d  = state_q;
    conteo_d = conteo_q;
    case (state_q)
      IDLE: begin
        case (pat)
          2'b10:   state_d = IN1;
          2'b01:   state_d = OUT1;
          2'b11:   state_d = ERR;
          default: ;
        endcase
      end
      IN1: begin
        case (pat)
          2'b11:   state_d = IN2;
          2'b00:   state_d = IDLE;
          2'b01:   state_d = ERR;
          default: ;
        endcase
      end
      IN2: begin
        case (pat)
          2'b01:   state_d = IN3;
          2'b10:   state_d = IN1;
          2'b00:   state_d = ERR;
          default: ;
        endcase
      end
      IN3: begin
        case (pat)
          2'b11: state_d = IN2;
          2'b10: state_d = ERR;
          2'b00: begin
            if (conteo_q == MaxCnt) begin
              state_d = ERR;
            end else begin
              state_d  = IDLE;
              conteo_d = conteo_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
      OUT1: begin
        case (pat)
          2'b11:   state_d = OUT2;
          2'b00:   state_d = IDLE;
          2'b10:   state_d = ERR;
          default: ;
        endcase
      end
      OUT2: begin
        case (pat)
          2'b10:   state_d = OUT3;
          2'b01:   state_d = OUT1;
          2'b00:   state_d = ERR;
          default: ;
        endcase
      end
      OUT3: begin
        case (pat)
          2'b11: state_d = OUT2;
          2'b01: state_d = ERR;
          2'b00: begin
            if (conteo_q == 4'd0) begin
              state_d = ERR;
            end else begin
              state_d  = IDLE;
              conteo_d = conteo_q - 4'd1;
            end
          end
          default: ;
        endcase
      end
      ERR: begin
        if (pat == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The error flag latches on the edge that enters ERR and only reset clears it.
  assign err_d = err_q | (state_d == ERR);

  assign conteo     = conteo_q;
  assign hubo_error = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_parking_meter_counter.sv
// Bench for parking_meter_counter: directed gate scenarios plus random sensor
// traffic, compared each cycle against a table-driven occupancy model.
module tb_parking_meter_counter;

  localparam int SYNC = 2;
  localparam int MAXC = 15;

  localparam logic [2:0] S_IDLE = 3'd0, S_IN1 = 3'd1, S_IN2 = 3'd2, S_IN3 = 3'd3,
                         S_OUT1 = 3'd4, S_OUT2 = 3'd5, S_OUT3 = 3'd6, S_ERR = 3'd7;

  logic       clk;
  logic       rst_n;
  logic       psensor, ssensor;
  logic [3:0] conteo;
  logic       hubo_error;
  logic [2:0] state;

  int npass = 0;
  int nchk  = 0;

  // Reference model: input delay line, transition table, count and error.
  logic [1:0] m_pipe [SYNC];
  logic [2:0] m_tab  [8][4];
  logic [2:0] m_st;
  logic [3:0] m_cnt;
  logic       m_err;

  parking_meter_counter #(.SYNC_STAGES(SYNC), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .reset(rst_n), .psensor(psensor), .ssensor(ssensor),
    .conteo(conteo), .hubo_error(hubo_error), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic build_table();
    for (int st = 0; st < 8; st++)
      for (int p = 0; p < 4; p++) m_tab[st][p] = 3'(st);
    m_tab[S_IDLE][2] = S_IN1;  m_tab[S_IDLE][1] = S_OUT1; m_tab[S_IDLE][3] = S_ERR;
    m_tab[S_IN1][3]  = S_IN2;  m_tab[S_IN1][0]  = S_IDLE; m_tab[S_IN1][1]  = S_ERR;
    m_tab[S_IN2][1]  = S_IN3;  m_tab[S_IN2][2]  = S_IN1;  m_tab[S_IN2][0]  = S_ERR;
    m_tab[S_IN3][3]  = S_IN2;  m_tab[S_IN3][2]  = S_ERR;  m_tab[S_IN3][0]  = S_IDLE;
    m_tab[S_OUT1][3] = S_OUT2; m_tab[S_OUT1][0] = S_IDLE; m_tab[S_OUT1][2] = S_ERR;
    m_tab[S_OUT2][2] = S_OUT3; m_tab[S_OUT2][1] = S_OUT1; m_tab[S_OUT2][0] = S_ERR;
    m_tab[S_OUT3][3] = S_OUT2; m_tab[S_OUT3][1] = S_ERR;  m_tab[S_OUT3][0] = S_IDLE;
    m_tab[S_ERR][0]  = S_IDLE;
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 2'b00;
    m_st = S_IDLE; m_cnt = 4'd0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] pin);
    logic [1:0] pat;
    logic [2:0] nxt;
    pat = m_pipe[SYNC-1];
    nxt = m_tab[m_st][pat];
    if (m_st == S_IN3 && pat == 2'b00) begin
      if (int'(m_cnt) == MAXC) nxt = S_ERR;
      else m_cnt = m_cnt + 4'd1;
    end
    if (m_st == S_OUT3 && pat == 2'b00) begin
      if (m_cnt == 4'd0) nxt = S_ERR;
      else m_cnt = m_cnt - 4'd1;
    end
    if (nxt == S_ERR) m_err = 1'b1;
    m_st = nxt;
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = pin;
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, compare at the next falling edge.
  task automatic cycle(input logic [1:0] ps);
    psensor = ps[1];
    ssensor = ps[0];
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(ps);
    @(negedge clk);
    check("state", 8'(state), 8'(m_st));
    check("conteo", 8'(conteo), 8'(m_cnt));
    check("hubo_error", 8'(hubo_error), 8'(m_err));
  endtask

  task automatic hold(input logic [1:0] ps, input int n);
    for (int i = 0; i < n; i++) cycle(ps);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    hold(2'b00, n);
    rst_n = 1'b1;
  endtask

  task automatic entry(input int h);
    hold(2'b10, h); hold(2'b11, h); hold(2'b01, h); hold(2'b00, h);
  endtask

  task automatic leave(input int h);
    hold(2'b01, h); hold(2'b11, h); hold(2'b10, h); hold(2'b00, h);
  endtask

  initial begin
    build_table();
    model_reset();
    psensor = 1'b0;
    ssensor = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);

    // Reset held, then idle
    do_reset(5);
    hold(2'b00, 3);
    check("idle_state", 8'(state), 8'd0);
    check("idle_cnt", 8'(conteo), 8'd0);

    // Back-out twice, then start an exit
    for (int r = 0; r < 2; r++) begin
      hold(2'b10, 3); check("bo_in1", 8'(state), 8'd1);
      hold(2'b11, 3); check("bo_in2", 8'(state), 8'd2);
      hold(2'b10, 3); check("bo_in1b", 8'(state), 8'd1);
      hold(2'b00, 3); check("bo_idle", 8'(state), 8'd0);
      check("bo_cnt", 8'(conteo), 8'd0);
      check("bo_err", 8'(hubo_error), 8'd0);
    end
    hold(2'b01, 3); check("out1", 8'(state), 8'd4);
    hold(2'b00, 3); check("out1_back", 8'(state), 8'd0);

    // Three entries, one exit
    for (int k = 1; k <= 3; k++) begin
      entry(3);
      check("entry_cnt", 8'(conteo), 8'(k));
    end
    leave(3);
    check("exit_cnt", 8'(conteo), 8'd2);
    check("exit_err", 8'(hubo_error), 8'd0);

    // Illegal jump from IDLE
    hold(2'b11, 3);
    check("jump_state", 8'(state), 8'd7);
    check("jump_err", 8'(hubo_error), 8'd1);
    hold(2'b00, 3);
    check("err_idle", 8'(state), 8'd0);
    check("err_sticky", 8'(hubo_error), 8'd1);
    entry(3);
    check("post_err_cnt", 8'(conteo), 8'd3);

    // Exit from an empty lot
    do_reset(2);
    leave(3);
    check("underflow_state", 8'(state), 8'd7);
    check("underflow_cnt", 8'(conteo), 8'd0);
    check("underflow_err", 8'(hubo_error), 8'd1);

    // Fill to MAX_COUNT, then one more
    do_reset(2);
    for (int k = 0; k < MAXC; k++) entry(3);
    check("full_cnt", 8'(conteo), 8'(MAXC));
    entry(3);
    check("overflow_state", 8'(state), 8'd7);
    check("overflow_cnt", 8'(conteo), 8'(MAXC));

    // Asynchronous reset while in IN2 with five cars
    do_reset(2);
    for (int k = 0; k < 5; k++) entry(3);
    hold(2'b10, 3);
    hold(2'b11, 3);
    check("pre_areset_state", 8'(state), 8'd2);
    check("pre_areset_cnt", 8'(conteo), 8'd5);
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", 8'(state), 8'd0);
    check("areset_cnt", 8'(conteo), 8'd0);
    check("areset_err", 8'(hubo_error), 8'd0);
    model_reset();
    @(negedge clk);
    hold(2'b00, 2);
    rst_n = 1'b1;

    // Random traffic with occasional resets
    for (int it = 0; it < 120; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (it % 15 == 14) do_reset(int'($urandom_range(1, 3)));
      else if (r < 4) entry(int'($urandom_range(1, 4)));
      else if (r < 7) leave(int'($urandom_range(1, 4)));
      else hold(2'($urandom), int'($urandom_range(1, 5)));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
